mac_operand_sequencer: RTL and testbench

- Drives one MAC unit: takes a dot-product job of N operand pairs, streams the pairs into the MAC's B/C inputs, then asserts the MAC's output_signal and captures the accumulated result.
- Returns the result on a valid/ready port, then clears the MAC for the next job.
- Sits between the operand buffers or controller and a MAC instance. It replaces hand-driven MAC stimulus.

---
 rtl/mac_operand_sequencer.sv | 142 ++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for a single MAC: streams N operand pairs, reads the accumulated
// result, returns it on a valid/ready port and clears the MAC. Optional macro: MAC_SEQ_STALL_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a job; cmd_ready high
// S_STREAM | accepting operand pairs; in_ready high
// S_FLUSH  | last pair is on mac_b/mac_c, MAC absorbs it at this edge
// S_READ   | mac_output_signal high; result captured at closing edge
// S_RESULT | res_valid high until res_ready; MAC cleared on first cycle
module mac_operand_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    output logic                  mac_reset,
    output logic                  mac_output_signal,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic [DATA_WIDTH-1:0] mac_c,
    input  logic [ACC_WIDTH-1:0]  mac_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_READ,
        S_RESULT
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_STREAM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= S_IDLE;
            remaining         <= '0;
            mac_b             <= '0;
            mac_c             <= '0;
            mac_output_signal <= 1'b0;
            mac_reset         <= 1'b1;
            res_valid         <= 1'b0;
            res_data          <= '0;
`ifdef MAC_SEQ_STALL_CNT_EN
            stall_cnt         <= '0;
            stall_cycles      <= '0;
`endif
        end else begin
            // Operands default to zero so the MAC never accumulates outside a real pair.
            mac_b             <= '0;
            mac_c             <= '0;
            mac_output_signal <= 1'b0;
            mac_reset         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
`ifdef MAC_SEQ_STALL_CNT_EN
                        stall_cnt <= '0;
`endif
                        if (cmd_len == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
`ifdef MAC_SEQ_STALL_CNT_EN
                            stall_cycles <= '0;
`endif
                            state     <= S_RESULT;
                        end else begin
                            remaining <= cmd_len;
                            state     <= S_STREAM;
                        end
                    end
                end

                S_STREAM: begin
                    if (in_valid) begin
                        mac_b     <= in_b;
                        mac_c     <= in_c;
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= S_FLUSH;
                        end
                    end
`ifdef MAC_SEQ_STALL_CNT_EN
                    else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
`endif
                end

                S_FLUSH: begin
                    mac_output_signal <= 1'b1;
                    state             <= S_READ;
                end

                S_READ: begin
                    res_data  <= mac_result;
                    res_valid <= 1'b1;
                    mac_reset <= 1'b1;
`ifdef MAC_SEQ_STALL_CNT_EN
                    stall_cycles <= stall_cnt;
`endif
                    state     <= S_RESULT;
                end

                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer: a behavioural MAC plus a dot-product
// reference with expected cycle-level timing derived from job length and stall placement.
module tb_mac_operand_sequencer;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_b;
    logic [DW-1:0] in_c;
    logic          mac_reset;
    logic          mac_output_signal;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_c;
    logic [AW-1:0] mac_result;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q_b[$];
    logic [DW-1:0] q_c[$];
    int            q_stall[$];

    always #5 clk = ~clk;

    mac_operand_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_b(in_b),
        .in_c(in_c),
        .mac_reset(mac_reset),
        .mac_output_signal(mac_output_signal),
        .mac_b(mac_b),
        .mac_c(mac_c),
        .mac_result(mac_result),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data)
`ifdef MAC_SEQ_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Behavioural MAC: accumulates every edge, cleared by mac_reset.
    logic [AW-1:0] acc;
    always @(posedge clk) begin
        if (mac_reset) acc <= '0;
        else           acc <= acc + AW'(mac_b) * AW'(mac_c);
    end
    assign mac_result = acc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the job described by q_b/q_c/q_stall; res_ready is held low for 'hold' result cycles.
    task automatic run_job(input string name, input int hold);
        logic          sv[$];
        logic [DW-1:0] sb[$];
        logic [DW-1:0] sc[$];
        int            n;
        int            len;
        int            total_stall;
        int            sum;
        int            exp_first;
        int            first_res;
        logic [AW-1:0] exp_res;
        logic          prev_v;
        logic [DW-1:0] prev_b;
        logic [DW-1:0] prev_c;
        logic [17:0]   expv;
        logic [17:0]   actv;

        n = q_b.size();
        total_stall = 0;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < q_stall[i]; s++) begin
                sv.push_back(1'b0);
                sb.push_back(DW'($urandom));
                sc.push_back(DW'($urandom));
                total_stall++;
            end
            sv.push_back(1'b1);
            sb.push_back(q_b[i]);
            sc.push_back(q_c[i]);
            sum += int'(q_b[i]) * int'(q_c[i]);
        end
        exp_res   = sum[AW-1:0];
        len       = sv.size();
        exp_first = (n == 0) ? 1 : len + 3;

        cmd_len   = LW'(n);
        cmd_valid = 1'b1;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready at handshake: got %b want 1", name, cmd_ready);
        else n_pass++;
        step();
        cmd_valid = 1'b0;

        prev_v = 1'b0;
        prev_b = '0;
        prev_c = '0;
        first_res = 0;
        for (int cyc = 1; cyc <= len + 10 && first_res == 0; cyc++) begin
            expv = {(cyc <= len) ? 1'b1 : 1'b0,
                    prev_v ? prev_b : 8'h00,
                    prev_v ? prev_c : 8'h00,
                    (n > 0 && cyc == len + 2) ? 1'b1 : 1'b0};
            actv = {in_ready, mac_b, mac_c, mac_output_signal};
            n_total++;
            if (actv !== expv)
                $display("FAIL %s cycle %0d in_ready/mac_b/mac_c/out_sig: got %h want %h", name, cyc, actv, expv);
            else n_pass++;
            if (res_valid) begin
                first_res = cyc;
            end else begin
                if (cyc <= len) begin
                    in_valid = sv[cyc-1];
                    in_b     = sb[cyc-1];
                    in_c     = sc[cyc-1];
                end else begin
                    in_valid = 1'b0;
                    in_b     = DW'($urandom);
                    in_c     = DW'($urandom);
                end
                prev_v    = in_valid;
                prev_b    = in_b;
                prev_c    = in_c;
                // Stray cmd_valid/res_ready before the result must be ignored.
                res_ready = (cyc + 1 < exp_first) ? 1'($urandom) : 1'b0;
                cmd_valid = (cyc + 1 < exp_first) ? 1'($urandom) : 1'b0;
                cmd_len   = LW'($urandom);
                step();
            end
        end
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;

        n_total++;
        if (first_res != exp_first) $display("FAIL %s res_valid latency: got %0d want %0d", name, first_res, exp_first);
        else n_pass++;
        n_total++;
        if (res_data !== exp_res) $display("FAIL %s res_data: got %0d want %0d", name, res_data, exp_res);
        else n_pass++;
        n_total++;
        if (mac_reset !== (n > 0)) $display("FAIL %s mac_reset first result cycle: got %b want %b", name, mac_reset, n > 0);
        else n_pass++;
`ifdef MAC_SEQ_STALL_CNT_EN
        n_total++;
        if (stall_cycles !== 16'(total_stall))
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, total_stall);
        else n_pass++;
`endif

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'($urandom);
            step();
            n_total++;
            if ({res_valid, res_data, cmd_ready, mac_reset} !== {1'b1, exp_res, 1'b0, 1'b0})
                $display("FAIL %s hold %0d valid/data/cmd_ready/mac_reset: got %b %0d %b %b want 1 %0d 0 0",
                         name, h, res_valid, res_data, cmd_ready, mac_reset, exp_res);
            else n_pass++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_total++;
        if ({res_valid, cmd_ready} !== 2'b01)
            $display("FAIL %s after handshake res_valid/cmd_ready: got %b%b want 01", name, res_valid, cmd_ready);
        else n_pass++;
        n_total++;
        if (acc !== '0) $display("FAIL %s MAC not cleared after job: acc got %0d want 0", name, acc);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_total++;
        if ({mac_reset, res_valid, mac_b, mac_c, mac_output_signal, res_data} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000})
            $display("FAIL reset outputs: got mr=%b rv=%b b=%0d c=%0d os=%b rd=%0d want mr=1 rv=0 b=0 c=0 os=0 rd=0",
                     mac_reset, res_valid, mac_b, mac_c, mac_output_signal, res_data);
        else n_pass++;
        reset = 1'b1;
        step();
        n_total++;
        if ({mac_reset, cmd_ready, in_ready} !== 3'b010)
            $display("FAIL reset release mac_reset/cmd_ready/in_ready: got %b%b%b want 010", mac_reset, cmd_ready, in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        q_b = '{5, 4, 6};
        q_c = '{3, 2, 3};
        q_stall = '{0, 0, 0};
        run_job("basic", 0);
    endtask

    task automatic test_stall();
        q_b = '{5, 4, 6};
        q_c = '{3, 2, 3};
        q_stall = '{0, 2, 0};
        run_job("stall", 0);
    endtask

    task automatic test_zero_len();
        q_b.delete();
        q_c.delete();
        q_stall.delete();
        run_job("zero_len", 0);
    endtask

    task automatic test_back_to_back();
        q_b = '{5, 4, 6};
        q_c = '{3, 2, 3};
        q_stall = '{0, 0, 0};
        run_job("hold_41", 5);
        q_b = '{2};
        q_c = '{2};
        q_stall = '{0};
        run_job("after_hold", 0);
    endtask

    task automatic test_midjob_reset();
        cmd_len   = 8'd4;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_b = 8'd3; in_c = 8'd3;
        step();
        in_b = 8'd2; in_c = 8'd5;
        step();
        in_b = 8'd9; in_c = 8'd9;
        reset = 1'b0;
        step();
        n_total++;
        if ({cmd_ready, in_ready, mac_reset, res_valid, mac_b, mac_c, mac_output_signal} !== {4'b1010, 16'h0000, 1'b0})
            $display("FAIL midjob reset state: got %b want %b",
                     {cmd_ready, in_ready, mac_reset, res_valid, mac_b, mac_c, mac_output_signal}, {4'b1010, 16'h0000, 1'b0});
        else n_pass++;
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        n_total++;
        if ({mac_reset, acc} !== {1'b0, 16'h0000})
            $display("FAIL midjob release mac_reset/acc: got %b %0d want 0 0", mac_reset, acc);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (res_valid !== 1'b0) $display("FAIL midjob aborted res_valid: got %b want 0", res_valid);
            else n_pass++;
        end
        q_b = '{7, 1};
        q_c = '{1, 1};
        q_stall = '{0, 0};
        run_job("after_abort", 0);
    endtask

    task automatic test_random();
        int n;
        for (int j = 0; j < 20; j++) begin
            q_b.delete();
            q_c.delete();
            q_stall.delete();
            n = (j == 7) ? 0 : ((j == 13) ? 40 : $urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                q_b.push_back(DW'($urandom_range(0, 255)));
                q_c.push_back(DW'($urandom_range(0, 255)));
                q_stall.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_job($sformatf("random_%0d", j), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_b      = '0;
        in_c      = '0;
        res_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_back_to_back();
        test_midjob_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
